seq_config_multiplier: RTL and testbench

Sequential, parametrised successor to the combinational configurable shift-add multiplier. It performs radix-2 shift-add multiplication one multiplier bit per cycle. Three precision modes are supported: one full-width product, two half-width SIMD lanes, or four quarter-width SIMD lanes. Operands can be signed or unsigned. It sits in the PE datapath behind valid/ready handshakes, so upstream operand buffers and downstream accumulators can stall it.

---
 rtl/config_mult_pkg.sv | 9 +
 rtl/config_mult_lane.sv | 36 +++
 rtl/seq_config_multiplier.sv | 69 ++++++
 tb/tb_seq_config_multiplier.sv | 125 ++++++++++++
 4 files changed

// File: rtl/config_mult_pkg.sv
// config_mult_pkg: shared types and lane-width helper for the sequential configurable multiplier
package config_mult_pkg;
  typedef enum logic [1:0] {PREC_FULL = 2'd0, PREC_HALF = 2'd1, PREC_QUARTER = 2'd2} prec_mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
  // reserved mode 3 falls through to full width
  function automatic int lane_width(input logic [1:0] mode, input int width);
    return mode == PREC_HALF ? width / 2 : mode == PREC_QUARTER ? width / 4 : width;
  endfunction
endpackage

// File: rtl/config_mult_lane.sv
// config_mult_lane: one radix-2 shift-add lane; acc shows the accumulator including the current step
module config_mult_lane #(
  parameter int LW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            step_en,
  input  logic            clear,
  input  logic            is_last,
  input  logic            sgn,
  input  logic [LW-1:0]   mcand,
  input  logic [LW-1:0]   mplier,
  output logic [2*LW-1:0] acc
);
  logic [2*LW-1:0] acc_q, mc;
  logic [LW-1:0]   mp;
  logic            sgn_q;
  // the top bit of a signed multiplier carries weight -2^(LW-1), hence the subtract
  assign acc = !mp[0] ? acc_q : (is_last && sgn_q) ? acc_q - mc : acc_q + mc;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      acc_q <= '0;
      mc    <= '0;
      mp    <= '0;
      sgn_q <= 1'b0;
    end else if (clear) begin
      acc_q <= '0;
      mc    <= sgn ? {{LW{mcand[LW-1]}}, mcand} : {{LW{1'b0}}, mcand};
      mp    <= mplier;
      sgn_q <= sgn;
    end else if (step_en) begin
      acc_q <= acc;
      mc    <= mc << 1;
      mp    <= mp >> 1;
    end
endmodule

// File: rtl/seq_config_multiplier.sv
// seq_config_multiplier: sequential shift-add multiplier with full/half/quarter SIMD lanes behind valid/ready
module seq_config_multiplier
  import config_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  input  logic [1:0]         prec_mode_i,
  input  logic               signed_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               busy_o
);
  localparam int CW = $clog2(WIDTH);
  state_e             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [1:0]         mode_q;
  logic               accept, last;
  logic [2*WIDTH-1:0] prod_full, prod_half, prod_quarter, prod_sel;
  assign in_ready_o  = state == IDLE;
  assign busy_o      = state == BUSY;
  assign out_valid_o = state == DONE;
  assign accept      = in_valid_i && in_ready_o;
  assign last        = cnt == CW'(lane_width(mode_q, WIDTH) - 1);
  assign prod_sel    = mode_q == PREC_HALF ? prod_half : mode_q == PREC_QUARTER ? prod_quarter : prod_full;
  always_comb
    state_nxt = state == IDLE ? (in_valid_i ? BUSY : IDLE) :
                state == BUSY ? (last ? DONE : BUSY) :
                (out_ready_i ? IDLE : DONE);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= PREC_FULL;
      product_o <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= '0;
        mode_q <= prec_mode_i;
      end else if (busy_o) cnt <= cnt + 1'b1;
      if (busy_o && last) product_o <= prod_sel;
    end
  // every lane group steps together; the latched mode only picks which group reaches product_o
  config_mult_lane #(.LW(WIDTH)) u_full (
    .clk_i, .rst_ni, .step_en(busy_o), .clear(accept), .is_last(cnt == CW'(WIDTH - 1)),
    .sgn(signed_i), .mcand(multiplicand_i), .mplier(multiplier_i), .acc(prod_full)
  );
  for (genvar h = 0; h < 2; h++) begin : g_half
    config_mult_lane #(.LW(WIDTH / 2)) u_lane (
      .clk_i, .rst_ni, .step_en(busy_o), .clear(accept), .is_last(cnt == CW'(WIDTH / 2 - 1)),
      .sgn(signed_i), .mcand(multiplicand_i[WIDTH/2*h +: WIDTH/2]),
      .mplier(multiplier_i[WIDTH/2*h +: WIDTH/2]), .acc(prod_half[WIDTH*h +: WIDTH])
    );
  end
  for (genvar q = 0; q < 4; q++) begin : g_quarter
    config_mult_lane #(.LW(WIDTH / 4)) u_lane (
      .clk_i, .rst_ni, .step_en(busy_o), .clear(accept), .is_last(cnt == CW'(WIDTH / 4 - 1)),
      .sgn(signed_i), .mcand(multiplicand_i[WIDTH/4*q +: WIDTH/4]),
      .mplier(multiplier_i[WIDTH/4*q +: WIDTH/4]), .acc(prod_quarter[WIDTH/2*q +: WIDTH/2])
    );
  end
endmodule

// File: tb/tb_seq_config_multiplier.sv
// tb_seq_config_multiplier: directed vectors with a queue scoreboard checked by a negedge monitor
module tb_seq_config_multiplier;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, sgn = 0;
  logic [W-1:0] mc = '0, mp = '0;
  logic [1:0] mode = '0;
  logic in_ready, out_valid, busy;
  logic [2*W-1:0] product;
  int cyc = 0, total = 0, bad = 0;
  logic was_v = 0;
  typedef struct {logic [2*W-1:0] exp; int lat; int acc;} exp_t;
  exp_t q[$];

  seq_config_multiplier #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .multiplicand_i(mc), .multiplier_i(mp), .prec_mode_i(mode), .signed_i(sgn),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .product_o(product), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && !was_v) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        chk("latency", cyc - q[0].acc, q[0].lat);
        chk("product_at_valid", {16'h0, product}, {16'h0, q[0].exp});
      end
    end
    if (out_valid && out_ready && q.size() > 0) begin
      chk("product_at_handshake", {16'h0, product}, {16'h0, q[0].exp});
      void'(q.pop_front());
    end
    was_v = out_valid;
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m,
                    input logic s, input logic [2*W-1:0] e, input int lat);
    wait_ready();
    mc = a; mp = b; mode = m; sgn = s; in_valid = 1;
    q.push_back('{e, lat, cyc + 1});
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);
    rst_n = 1;
    @(posedge clk); #1;
    op(8'hFD, 8'h03, 2'd0, 1, 16'hFFF7, 8);
    op(8'hFF, 8'hFF, 2'd0, 0, 16'hFE01, 8);
    op(8'h7F, 8'h81, 2'd0, 1, 16'hC0FF, 8);
    op(8'h12, 8'h34, 2'd3, 0, 16'h03A8, 8);
    op(8'h3D, 8'h33, 2'd1, 1, 16'h09F7, 4);
    op(8'hFF, 8'hFF, 2'd1, 0, 16'hE1E1, 4);
    op(8'hFF, 8'hFF, 2'd2, 0, 16'h9999, 2);
    op(8'hFF, 8'hFF, 2'd2, 1, 16'h1111, 2);
    // backpressure: hold the product in DONE for five cycles
    wait_ready();
    out_ready = 0;
    op(8'h05, 8'hFB, 2'd0, 1, 16'hFFE7, 8);
    for (int n = 0; n < 20 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    chk("bp_valid_reached", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_product_hold", product, 16'hFFE7);
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp_idle_after_release", in_ready, 1);
    chk("bp_valid_dropped", out_valid, 0);
    // operands and mode wander while BUSY; only the latched values may count
    op(8'h0A, 8'h0B, 2'd0, 0, 16'h006E, 8);
    for (int i = 0; i < 6; i++) begin
      mc = W'($urandom); mp = W'($urandom); mode = 2'($urandom); sgn = 1'($urandom);
      @(posedge clk); #1;
    end
    wait_ready();
    // reset during BUSY step 3 must abort with nothing presented
    mc = 8'hFD; mp = 8'h03; mode = 2'd0; sgn = 1; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_product", product, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    op(8'h80, 8'h80, 2'd0, 1, 16'h4000, 8);
    for (int n = 0; n < 200 && q.size() > 0; n++) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
